// File: rtl/inst_encoder_loader_pkg.sv
// Shared encodings, control bundle layout and FSM states for the instruction encoder/loader.
package inst_encoder_loader_pkg;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned REG_W  = 3;
  localparam int unsigned IMM_W  = 6;
  localparam int unsigned FS_W   = 3;
  localparam int unsigned BS_W   = 3;

  localparam logic [OP_W-1:0] OP_RTYPE = 4'b1111;
  localparam logic [OP_W-1:0] OP_LW    = 4'b0010;
  localparam logic [OP_W-1:0] OP_SW    = 4'b0100;
  localparam logic [OP_W-1:0] OP_ADDI  = 4'b0101;
  localparam logic [OP_W-1:0] OP_0110  = 4'b0110;
  localparam logic [OP_W-1:0] OP_BEQ   = 4'b1000;
  localparam logic [OP_W-1:0] OP_BNE   = 4'b1001;
  localparam logic [OP_W-1:0] OP_BGEZ  = 4'b1010;
  localparam logic [OP_W-1:0] OP_BLTZ  = 4'b1011;

  localparam logic [BS_W-1:0] BS_EQ   = 3'b000;
  localparam logic [BS_W-1:0] BS_NE   = 3'b001;
  localparam logic [BS_W-1:0] BS_GEZ  = 3'b010;
  localparam logic [BS_W-1:0] BS_LTZ  = 3'b011;
  localparam logic [BS_W-1:0] BS_NONE = 3'b100;

  localparam logic [FS_W-1:0] FS_ADDI = 3'b000;
  localparam logic [FS_W-1:0] FS_0110 = 3'b101;

  localparam logic [WORD_W-1:0] HLT_WORD = 16'h0001;
  localparam logic [WORD_W-1:0] NOP_WORD = 16'h0000;

  typedef struct packed {
    logic [REG_W-1:0] dr;
    logic [REG_W-1:0] sa;
    logic [REG_W-1:0] sb;
    logic [IMM_W-1:0] imm;
    logic [IMM_W-1:0] off;
    logic [FS_W-1:0]  fs;
    logic [BS_W-1:0]  bs;
    logic             mb;
    logic             md;
    logic             ld;
    logic             mw;
    logic             hlt;
  } ctrl_bundle_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2,
    ST_FULL = 2'd3
  } state_t;

endpackage

// File: rtl/inst_encode_comb.sv
// Re-encodes a decoded control bundle into a 16-bit instruction word; flags combinations no decoder emits.
module inst_encode_comb
  import inst_encoder_loader_pkg::*;
(
  input  ctrl_bundle_t       bundle,
  output logic [WORD_W-1:0]  word_c,
  output logic               illegal_c
);

  always_comb begin
    word_c    = NOP_WORD;
    illegal_c = 1'b0;
    if (bundle.hlt) begin
      word_c = HLT_WORD;
    end else begin
      unique case (bundle.bs)
        BS_EQ:   word_c = {OP_BEQ,  bundle.sa, bundle.sb, bundle.off};
        BS_NE:   word_c = {OP_BNE,  bundle.sa, bundle.sb, bundle.off};
        BS_GEZ:  word_c = {OP_BGEZ, bundle.sa, 3'b000,    bundle.off};
        BS_LTZ:  word_c = {OP_BLTZ, bundle.sa, 3'b000,    bundle.off};
        BS_NONE: begin
          // A bundle that both loads a register and writes memory has no encoding
          if (bundle.ld && bundle.mw) begin
            illegal_c = 1'b1;
          end else if (bundle.mw) begin
            word_c = {OP_SW, bundle.sa, bundle.sb, bundle.imm};
          end else if (!bundle.ld) begin
            word_c = NOP_WORD;
          end else if (bundle.mb && bundle.md) begin
            word_c = {OP_LW, bundle.sa, bundle.dr, bundle.imm};
          end else if (bundle.mb && bundle.fs == FS_ADDI) begin
            word_c = {OP_ADDI, bundle.sa, bundle.dr, bundle.imm};
          end else if (bundle.mb && bundle.fs == FS_0110) begin
            word_c = {OP_0110, bundle.sa, bundle.dr, bundle.imm};
          end else if (!bundle.mb && !bundle.md) begin
            word_c = {OP_RTYPE, bundle.sa, bundle.sb, bundle.dr, bundle.fs};
          end else begin
            illegal_c = 1'b1;
          end
        end
        default: illegal_c = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/inst_encoder_loader.sv
// Session FSM that encodes accepted control bundles and streams them into sequential IMEM words.
module inst_encoder_loader
  import inst_encoder_loader_pkg::*;
#(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        dr,
  input  logic [2:0]        sa,
  input  logic [2:0]        sb,
  input  logic [5:0]        imm,
  input  logic [5:0]        off,
  input  logic [2:0]        fs,
  input  logic [2:0]        bs,
  input  logic              mb,
  input  logic              md,
  input  logic              ld,
  input  logic              mw,
  input  logic              hlt,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [15:0]       imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              done,
  output logic              full,
  output logic              err
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] BASE_PTR = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST_PTR = {ADDR_W{1'b1}};

  ctrl_bundle_t       bundle;
  logic [WORD_W-1:0]  enc_word;
  logic               enc_illegal;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [WORD_W-1:0]  wdata_q, wdata_d;
  logic               we_q, we_d;
  logic               err_q, err_d;
  logic               done_q, full_q;

  assign bundle = '{dr: dr, sa: sa, sb: sb, imm: imm, off: off, fs: fs,
                    bs: bs, mb: mb, md: md, ld: ld, mw: mw, hlt: hlt};

  inst_encode_comb u_encode (
    .bundle    (bundle),
    .word_c    (enc_word),
    .illegal_c (enc_illegal)
  );

  // Ready is a pure decode of the state register
  assign in_ready = (state_q == ST_LOAD);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    err_d   = err_q;
    unique case (state_q)
      ST_LOAD: begin
        if (in_valid) begin
          we_d    = 1'b1;
          addr_d  = ptr_q;
          wdata_d = enc_word;
          cnt_d   = cnt_q + CNT_W'(1);
          err_d   = err_q | enc_illegal;
          // Pointer saturates at the top address; the session ends there
          if (ptr_q != LAST_PTR) ptr_d = ptr_q + ADDR_W'(1);
          if (hlt) begin
            state_d = ST_DONE;
          end else if (ptr_q == LAST_PTR) begin
            state_d = ST_FULL;
          end
        end
      end
      default: begin
        if (start) begin
          state_d = ST_LOAD;
          ptr_d   = BASE_PTR;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= BASE_PTR;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      full_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      err_q   <= err_d;
      done_q  <= (state_d == ST_DONE);
      full_q  <= (state_d == ST_FULL);
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign count      = cnt_q;
  assign done       = done_q;
  assign full       = full_q;
  assign err        = err_q;

endmodule

// File: tb/tb_inst_encoder_loader.sv
// Bench for inst_encoder_loader: directed scenarios plus a randomized session run against a reference model.
module tb_inst_encoder_loader;
  import inst_encoder_loader_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_a = 1'b0, start_b = 1'b0;
  logic in_valid_a = 1'b0, in_valid_b = 1'b0;
  ctrl_bundle_t bnd = '0;

  logic       ready_a, we_a, done_a, full_a, err_a;
  logic [7:0] addr_a;
  logic [15:0] wdata_a;
  logic [8:0] count_a;

  logic       ready_b, we_b, done_b, full_b, err_b;
  logic [1:0] addr_b;
  logic [15:0] wdata_b;
  logic [2:0] count_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  inst_encoder_loader #(.ADDR_W(8), .BASE_ADDR(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .in_valid(in_valid_a), .in_ready(ready_a),
    .dr(bnd.dr), .sa(bnd.sa), .sb(bnd.sb), .imm(bnd.imm), .off(bnd.off), .fs(bnd.fs),
    .bs(bnd.bs), .mb(bnd.mb), .md(bnd.md), .ld(bnd.ld), .mw(bnd.mw), .hlt(bnd.hlt),
    .imem_we(we_a), .imem_addr(addr_a), .imem_wdata(wdata_a), .count(count_a),
    .done(done_a), .full(full_a), .err(err_a));

  inst_encoder_loader #(.ADDR_W(2), .BASE_ADDR(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .in_valid(in_valid_b), .in_ready(ready_b),
    .dr(bnd.dr), .sa(bnd.sa), .sb(bnd.sb), .imm(bnd.imm), .off(bnd.off), .fs(bnd.fs),
    .bs(bnd.bs), .mb(bnd.mb), .md(bnd.md), .ld(bnd.ld), .mw(bnd.mw), .hlt(bnd.hlt),
    .imem_we(we_b), .imem_addr(addr_b), .imem_wdata(wdata_b), .count(count_b),
    .done(done_b), .full(full_b), .err(err_b));

  // Reference encoder: field values combined arithmetically from the opcode table
  function automatic logic [16:0] ref_enc(input ctrl_bundle_t b);
    int op, rs, rt, lo;
    bit bad;
    op = 0; rs = 0; rt = 0; lo = 0; bad = 1'b0;
    if (b.hlt) lo = 1;
    else if (int'(b.bs) <= 1) begin op = 8 + int'(b.bs); rs = b.sa; rt = b.sb; lo = b.off; end
    else if (int'(b.bs) <= 3) begin op = 8 + int'(b.bs); rs = b.sa; lo = b.off; end
    else if (int'(b.bs) == 4) begin
      if (b.ld && b.mw) bad = 1'b1;
      else if (b.mw) begin op = 4; rs = b.sa; rt = b.sb; lo = b.imm; end
      else if (!b.ld) op = 0;
      else if (b.mb && b.md) begin op = 2; rs = b.sa; rt = b.dr; lo = b.imm; end
      else if (b.mb && b.fs == 0) begin op = 5; rs = b.sa; rt = b.dr; lo = b.imm; end
      else if (b.mb && b.fs == 5) begin op = 6; rs = b.sa; rt = b.dr; lo = b.imm; end
      else if (!b.mb && !b.md) begin op = 15; rs = b.sa; rt = b.sb; lo = b.dr * 8 + b.fs; end
      else bad = 1'b1;
    end else bad = 1'b1;
    return {bad, 16'(op * 4096 + rs * 512 + rt * 64 + lo)};
  endfunction

  function automatic ctrl_bundle_t mk(input int dr, sa, sb, imm, off, fs, bs,
                                      input bit mb, md, ld, mw, hlt);
    ctrl_bundle_t b;
    b = '{dr: 3'(dr), sa: 3'(sa), sb: 3'(sb), imm: 6'(imm), off: 6'(off), fs: 3'(fs),
          bs: 3'(bs), mb: mb, md: md, ld: ld, mw: mw, hlt: hlt};
    return b;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; in_valid_a = 1'b0; in_valid_b = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic pulse_start_a();
    start_a = 1'b1; @(posedge clk); #1 start_a = 1'b0;
  endtask

  task automatic pulse_start_b();
    start_b = 1'b1; @(posedge clk); #1 start_b = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; #3;
    checks++; if ({we_a, ready_a, done_a, full_a, err_a} !== 5'b0) begin errors++; $display("FAIL reset_flags got=%b exp=00000", {we_a, ready_a, done_a, full_a, err_a}); end
    checks++; if (addr_a !== 8'd0 || wdata_a !== 16'd0 || count_a !== 9'd0) begin errors++; $display("FAIL reset_regs got addr=%0h wdata=%0h count=%0d exp 0", addr_a, wdata_a, count_a); end
    do_reset();
  endtask

  task automatic test_rtype();
    do_reset(); pulse_start_a();
    checks++; if (ready_a !== 1'b1 || count_a !== 9'd0) begin errors++; $display("FAIL start_load got ready=%b count=%0d exp ready=1 count=0", ready_a, count_a); end
    bnd = mk(3, 1, 2, 0, 0, 0, 4, 0, 0, 1, 0, 0); in_valid_a = 1'b1;
    @(posedge clk); #1 in_valid_a = 1'b0;
    checks++; if (we_a !== 1'b1 || addr_a !== 8'd0 || wdata_a !== 16'hF298 || count_a !== 9'd1) begin errors++; $display("FAIL rtype_write got we=%b addr=%0h wdata=%h count=%0d exp we=1 addr=0 wdata=f298 count=1", we_a, addr_a, wdata_a, count_a); end
    @(posedge clk); #1;
    checks++; if (we_a !== 1'b0) begin errors++; $display("FAIL rtype_we_drop got=%b exp=0", we_a); end
  endtask

  task automatic test_back_to_back();
    do_reset(); pulse_start_a();
    bnd = mk(2, 1, 0, 5, 0, 0, 4, 1, 1, 1, 0, 0); in_valid_a = 1'b1;
    @(posedge clk); #1;
    checks++; if (we_a !== 1'b1 || addr_a !== 8'd0 || wdata_a !== 16'h2285) begin errors++; $display("FAIL b2b_lw got we=%b addr=%0h wdata=%h exp we=1 addr=0 wdata=2285", we_a, addr_a, wdata_a); end
    bnd = mk(0, 3, 4, 0, 6'h3E, 0, 1, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    checks++; if (we_a !== 1'b1 || addr_a !== 8'd1 || wdata_a !== 16'h973E) begin errors++; $display("FAIL b2b_bne got we=%b addr=%0h wdata=%h exp we=1 addr=1 wdata=973e", we_a, addr_a, wdata_a); end
    bnd = mk(0, 0, 0, 0, 0, 0, 4, 0, 0, 0, 0, 1);
    @(posedge clk); #1;
    checks++; if (we_a !== 1'b1 || addr_a !== 8'd2 || wdata_a !== 16'h0001) begin errors++; $display("FAIL hlt_write got we=%b addr=%0h wdata=%h exp we=1 addr=2 wdata=0001", we_a, addr_a, wdata_a); end
    checks++; if (done_a !== 1'b1 || ready_a !== 1'b0 || count_a !== 9'd3) begin errors++; $display("FAIL hlt_done got done=%b ready=%b count=%0d exp done=1 ready=0 count=3", done_a, ready_a, count_a); end
    bnd = mk(1, 1, 1, 1, 1, 0, 4, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++; if (we_a !== 1'b0 || count_a !== 9'd3 || done_a !== 1'b1) begin errors++; $display("FAIL done_hold cyc=%0d got we=%b count=%0d done=%b exp we=0 count=3 done=1", i, we_a, count_a, done_a); end
    end
    in_valid_a = 1'b0; pulse_start_a();
    checks++; if (ready_a !== 1'b1 || count_a !== 9'd0 || done_a !== 1'b0) begin errors++; $display("FAIL restart got ready=%b count=%0d done=%b exp ready=1 count=0 done=0", ready_a, count_a, done_a); end
  endtask

  task automatic test_full();
    do_reset(); pulse_start_b();
    bnd = mk(0, 0, 0, 0, 0, 0, 4, 0, 0, 0, 0, 0); in_valid_b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++; if (we_b !== 1'b1 || addr_b !== 2'(i) || wdata_b !== 16'h0000) begin errors++; $display("FAIL full_fill i=%0d got we=%b addr=%0d wdata=%h exp we=1 addr=%0d wdata=0000", i, we_b, addr_b, wdata_b, i); end
    end
    checks++; if (full_b !== 1'b1 || done_b !== 1'b0 || count_b !== 3'd4 || ready_b !== 1'b0) begin errors++; $display("FAIL full_state got full=%b done=%b count=%0d ready=%b exp full=1 done=0 count=4 ready=0", full_b, done_b, count_b, ready_b); end
    @(posedge clk); #1;
    checks++; if (we_b !== 1'b0 || addr_b !== 2'd3 || count_b !== 3'd4) begin errors++; $display("FAIL full_nowrap got we=%b addr=%0d count=%0d exp we=0 addr=3 count=4", we_b, addr_b, count_b); end
    in_valid_b = 1'b0; pulse_start_b(); in_valid_b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bnd = mk(0, 0, 0, 0, 0, 0, 4, 0, 0, 0, 0, (i == 3));
      @(posedge clk); #1;
    end
    in_valid_b = 1'b0;
    checks++; if (done_b !== 1'b1 || full_b !== 1'b0 || count_b !== 3'd4 || wdata_b !== 16'h0001 || addr_b !== 2'd3) begin errors++; $display("FAIL hlt_at_last got done=%b full=%b count=%0d wdata=%h addr=%0d exp done=1 full=0 count=4 wdata=0001 addr=3", done_b, full_b, count_b, wdata_b, addr_b); end
  endtask

  task automatic test_illegal();
    do_reset(); pulse_start_a();
    bnd = mk(5, 6, 7, 9, 9, 3, 7, 1, 1, 1, 0, 0); in_valid_a = 1'b1;
    @(posedge clk); #1;
    checks++; if (we_a !== 1'b1 || wdata_a !== 16'h0000 || err_a !== 1'b1) begin errors++; $display("FAIL illegal_write got we=%b wdata=%h err=%b exp we=1 wdata=0000 err=1", we_a, wdata_a, err_a); end
    bnd = mk(3, 1, 2, 0, 0, 0, 4, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++; if (err_a !== 1'b1 || wdata_a !== 16'hF298) begin errors++; $display("FAIL err_sticky i=%0d got err=%b wdata=%h exp err=1 wdata=f298", i, err_a, wdata_a); end
    end
    bnd = mk(0, 0, 0, 0, 0, 0, 4, 0, 0, 0, 0, 1);
    @(posedge clk); #1 in_valid_a = 1'b0;
    pulse_start_a();
    checks++; if (err_a !== 1'b0 || ready_a !== 1'b1) begin errors++; $display("FAIL err_clear got err=%b ready=%b exp err=0 ready=1", err_a, ready_a); end
  endtask

  task automatic test_reset_mid();
    do_reset(); pulse_start_a();
    bnd = mk(3, 1, 2, 0, 0, 0, 4, 0, 0, 1, 0, 0); in_valid_a = 1'b1;
    @(posedge clk); #1;
    checks++; if (we_a !== 1'b1) begin errors++; $display("FAIL mid_we_pre got=%b exp=1", we_a); end
    #1 rst_n = 1'b0; #1;
    checks++; if ({we_a, ready_a, done_a, full_a, err_a} !== 5'b0 || addr_a !== 8'd0 || wdata_a !== 16'd0 || count_a !== 9'd0) begin errors++; $display("FAIL mid_reset got we=%b ready=%b addr=%0h wdata=%h count=%0d exp all 0", we_a, ready_a, addr_a, wdata_a, count_a); end
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (ready_a !== 1'b0 || we_a !== 1'b0 || count_a !== 9'd0) begin errors++; $display("FAIL post_reset_idle got ready=%b we=%b count=%0d exp ready=0 we=0 count=0", ready_a, we_a, count_a); end
    in_valid_a = 1'b0;
  endtask

  function automatic ctrl_bundle_t rand_bundle();
    ctrl_bundle_t b;
    b.dr = 3'($urandom); b.sa = 3'($urandom); b.sb = 3'($urandom);
    b.imm = 6'($urandom); b.off = 6'($urandom);
    b.fs = ($urandom_range(0, 2) == 0) ? 3'd5 : (($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom));
    b.bs = ($urandom_range(0, 1) == 0) ? 3'd4 : 3'($urandom);
    b.mb = 1'($urandom); b.md = 1'($urandom); b.ld = 1'($urandom);
    b.mw = b.ld ? 1'b0 : 1'($urandom);
    b.hlt = ($urandom_range(0, 39) == 0);
    return b;
  endfunction

  // Session-level model: loading flag, next address, words written, error seen, end reason
  task automatic test_random();
    bit loading, ended_done, ended_full, m_err, v, s, exp_we;
    int m_ptr, m_cnt, exp_addr, exp_wdata;
    logic [16:0] r;
    ctrl_bundle_t b;
    do_reset();
    loading = 0; ended_done = 0; ended_full = 0; m_err = 0;
    m_ptr = 0; m_cnt = 0; exp_addr = 0; exp_wdata = 0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      b = rand_bundle();
      v = ($urandom_range(0, 3) != 0);
      s = (!loading) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
      bnd = b; in_valid_a = v; start_a = s;
      @(posedge clk);
      exp_we = 0;
      if (loading) begin
        if (v) begin
          r = ref_enc(b);
          exp_we = 1; exp_addr = m_ptr; exp_wdata = r[15:0];
          m_err = m_err | r[16]; m_cnt++;
          if (b.hlt) begin loading = 0; ended_done = 1; end
          else if (m_ptr == 255) begin loading = 0; ended_full = 1; end
          else m_ptr++;
        end
      end else if (s) begin
        loading = 1; ended_done = 0; ended_full = 0; m_ptr = 0; m_cnt = 0; m_err = 0;
      end
      #1;
      checks++; if (we_a !== exp_we || addr_a !== 8'(exp_addr) || wdata_a !== 16'(exp_wdata)) begin errors++; $display("FAIL rand_write cyc=%0d got we=%b addr=%0h wdata=%h exp we=%b addr=%0h wdata=%h", cyc, we_a, addr_a, wdata_a, exp_we, exp_addr, exp_wdata); end
      checks++; if (count_a !== 9'(m_cnt) || err_a !== m_err || ready_a !== loading || done_a !== ended_done || full_a !== ended_full) begin errors++; $display("FAIL rand_state cyc=%0d got count=%0d err=%b ready=%b done=%b full=%b exp count=%0d err=%b ready=%b done=%b full=%b", cyc, count_a, err_a, ready_a, done_a, full_a, m_cnt, m_err, loading, ended_done, ended_full); end
    end
    in_valid_a = 1'b0; start_a = 1'b0;
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_back_to_back();
    test_full();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_encoder_loader.md
Name: inst_encoder_loader

Overview:
- Inverse of the CPU instruction decoder: takes a decoded control bundle (DR/SA/SB/IMM/MB/FS/MD/LD/MW/HLT/BS/OFF) and re-encodes it into the 16-bit instruction word.
- Each encoded word is written sequentially into instruction memory.
- Sits between the test/boot host and the IMEM write port; used for program loading and for decoder round-trip checking.
- Runs a session: START, then a stream of valid/ready bundles, ending on HLT or when memory is full.

Parameters:
ADDR_W, 8, IMEM address width; depth = 2^ADDR_W words
BASE_ADDR, 0, first write address of a session

Ports:
CLK  input  1  clock, rising edge
RST_N  input  1  reset, asynchronous, active-low
START  input  1  begin session; honoured only in IDLE, DONE or FULL
IN_VALID  input  1  control bundle valid
IN_READY  output  1  bundle accepted when IN_VALID && IN_READY at a rising edge
DR, SA, SB  input  3 each  register fields
IMM, OFF  input  6 each  immediate / branch offset
FS, BS  input  3 each  function select / branch select
MB, MD, LD, MW, HLT  input  1 each  control bits
IMEM_WE  output  1  write strobe, one cycle per word
IMEM_ADDR  output  ADDR_W  write address
IMEM_WDATA  output  16  encoded word
COUNT  output  ADDR_W+1  words written this session
DONE  output  1  high in DONE state
FULL  output  1  high in FULL state
ERR  output  1  sticky: an illegal bundle was seen this session

Behaviour:
- Word layout: OP[15:12] RS[11:9] RT[8:6] RD[5:3] FUNCT[2:0]; IMM/OFF occupy [5:0]. Unused fields encode as 0.
- Encode priority (first match wins):
  - HLT=1 -> 0x0001.
  - BS=000 -> OP 1000 (BEQ), RS=SA, RT=SB, [5:0]=OFF.
  - BS=001 -> OP 1001 (BNE), same field mapping as BEQ.
  - BS=010 -> OP 1010 (BGEZ), RS=SA, RT=0, [5:0]=OFF.
  - BS=011 -> OP 1011 (BLTZ), RS=SA, RT=0, [5:0]=OFF.
  - BS=100, MW=1, LD=0 -> OP 0100 (SW), RS=SA, RT=SB, IMM.
  - BS=100, LD=1, MB=1, MD=1 -> OP 0010 (LW), RS=SA, RT=DR, IMM.
  - BS=100, LD=1, MB=1, MD=0, FS=000 -> OP 0101, RS=SA, RT=DR, IMM.
  - BS=100, LD=1, MB=1, MD=0, FS=101 -> OP 0110, same field mapping as OP 0101.
  - BS=100, LD=1, MB=0, MD=0 -> OP 1111, RS=SA, RT=SB, RD=DR, FUNCT=FS.
  - BS=100, LD=0, MW=0 -> 0x0000 (NOP).
  - Anything else (BS 101-111, LD&MW, other FS with MB=1, MD=1 with MB=0) is illegal: write 0x0000, set ERR.
- FSM states: IDLE, LOAD, DONE, FULL.
- Reset values: state=IDLE, IN_READY=0, IMEM_WE=0, IMEM_ADDR=0, IMEM_WDATA=0, COUNT=0, DONE=0, FULL=0, ERR=0, write pointer=BASE_ADDR.
- IN_READY is a combinational decode of the state: 1 only in LOAD.
- START handling:
  - In IDLE, DONE or FULL: go to LOAD; pointer=BASE_ADDR, COUNT=0, ERR=0.
  - In LOAD: ignored.
- Accept edge: IMEM_WE<=1, IMEM_ADDR<=pointer, IMEM_WDATA<=encoded word, pointer+=1, COUNT+=1.
  - Latency is exactly 1 cycle from accept edge to write strobe.
  - Throughput is one word per cycle.
  - IMEM_WE deasserts on the next edge with no accept.
- Accepted bundle has HLT=1 -> HLT word is written, state=DONE.
- Accepted non-HLT bundle at pointer = 2^ADDR_W-1 -> word is written, state=FULL. The pointer never wraps.
- HLT accepted at the last address -> DONE takes priority over FULL.
- DONE/FULL persist until START or reset. IN_VALID is ignored there.
- Reset asserted mid-session: all state clears immediately (asynchronous). An in-flight IMEM_WE drops without completing.
- ERR does not stop the session.

Decomposition:
- Shared package:
  - OP code constants (OP_RTYPE=1111, OP_LW=0010, OP_SW=0100, OP_ADDI=0101, OP_0110, OP_BEQ..OP_BLTZ).
  - BS encodings (BS_EQ=000 .. BS_NONE=100), HLT_WORD=16'h0001, NOP_WORD=16'h0000.
  - FSM state enum.
- One combinational sub-module inst_encode_comb (bundle -> 16-bit word + illegal flag). The FSM, pointer and output registers live in the top.

Test Plan:
- Reset, then START, then R-type DR=3 SA=1 SB=2 FS=000 LD=1 BS=100 -> one cycle later IMEM_WE=1, ADDR=0, WDATA=0xF298, COUNT=1.
- LW DR=2 SA=1 IMM=5 MB=1 MD=1 LD=1, then BNE SA=3 SB=4 OFF=0x3E BS=001 on back-to-back cycles -> writes 0x2285 @0 then 0x973E @1, no bubble.
- HLT=1 after two words -> writes 0x0001 @2, DONE=1, IN_READY=0; further IN_VALID produces no writes; START returns to LOAD with COUNT=0.
- ADDR_W=2, 4 non-HLT NOPs -> writes @0..3, FULL=1, COUNT=4, no wrap; with HLT as the 4th word -> DONE=1, FULL=0.
- Illegal BS=111 -> WDATA=0x0000 written, ERR=1 stays set over subsequent legal words until the next START.
- RST_N pulled low while IMEM_WE=1 -> all outputs 0 immediately without waiting for a clock; after release, state is IDLE.
